alu_arbiter: RTL and testbench

Two-requester round-robin scheduler that shares a single combinational `alu` instance (`DATA_WIDTH` operands, 3-bit `op`, `result`/`zero` outputs). It accepts operation requests over valid/ready handshakes and registers the operands onto the ALU. It captures the ALU result one cycle later and returns it to the granted requester over a per-port valid/ready response channel. It also keeps an 8-bit completed-operation count for status. It sits between `top`-level requesters and `u_alu`, replacing direct operand wiring.

---
 rtl/alu_arbiter.sv | 151 +++++++++++++++
 tb/tb_alu_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Round-robin scheduler that lets two requesters share one combinational ALU.
// An operation is accepted over a valid/ready handshake, its operands are
// registered onto the ALU, the ALU result is captured one cycle later, and it
// is returned to the requester that issued it over a per-port valid/ready
// response channel. Only one operation is in flight at a time.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req{0,1}_valid/_ready      request handshake, per requester
//   req{0,1}_a/_b/_op          operands and opcode, per requester
//   rsp{0,1}_valid/_ready      response handshake, per requester
//   rsp{0,1}_result/_zero      captured ALU result and zero flag
//   alu_a/_b/_op               registered operands driven to the ALU
//   alu_result/_zero           combinational ALU outputs
//   busy                       high whenever an operation is in flight
//   op_count                   completed response handshakes, wraps at 256
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic [2:0]            req0_op,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    input  logic [2:0]            req1_op,

    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic [DATA_WIDTH-1:0] rsp0_result,
    output logic                  rsp0_zero,

    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [DATA_WIDTH-1:0] rsp1_result,
    output logic                  rsp1_zero,

    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [2:0]            alu_op,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero,

    output logic                  busy,
    output logic [7:0]            op_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]            state;
    logic                  last_grant;   // port that completed most recently
    logic                  owner;        // port whose operation is in flight
    logic [DATA_WIDTH-1:0] cap_result;
    logic                  cap_zero;

    logic [1:0]            grant;
    logic                  accept;
    logic                  owner_ready;
    logic                  rsp_done;

    // Grant: a lone requester wins outright; on a tie the port that did not
    // complete last wins, which guarantees each side a turn under contention.
    always_comb begin
        // NOTE: default assignment first so no path through the block leaves
        // grant unassigned; otherwise a latch is inferred.
        grant = 2'b00;
        if (req0_valid && req1_valid) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end else if (req0_valid) begin
            grant = 2'b01;
        end else if (req1_valid) begin
            grant = 2'b10;
        end
    end

    assign req0_ready  = (state == S_IDLE) && grant[0];
    assign req1_ready  = (state == S_IDLE) && grant[1];
    assign accept      = req0_ready || req1_ready;

    assign owner_ready = owner ? rsp1_ready : rsp0_ready;
    assign rsp_done    = (state == S_RESP) && owner_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;   // port 0 wins the first tie
            owner      <= 1'b0;
            cap_result <= '0;
            cap_zero   <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= 3'd0;
            op_count   <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments for all registered state so every
            // register samples pre-edge values regardless of statement order.
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        // Operands are latched here, so the requester may drop
                        // valid or change operands freely once accepted.
                        alu_a  <= req1_ready ? req1_a  : req0_a;
                        alu_b  <= req1_ready ? req1_b  : req0_b;
                        alu_op <= req1_ready ? req1_op : req0_op;
                        owner  <= req1_ready;
                        state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // ALU inputs have been stable for the whole cycle.
                    cap_result <= alu_result;
                    cap_zero   <= alu_zero;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_done) begin
                        last_grant <= owner;
                        op_count   <= op_count + 8'd1;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Both response ports read the shared capture registers; the data is
    // meaningful only while the matching valid is high.
    assign rsp0_valid  = (state == S_RESP) && !owner;
    assign rsp1_valid  = (state == S_RESP) &&  owner;
    assign rsp0_result = cap_result;
    assign rsp1_result = cap_result;
    assign rsp0_zero   = cap_zero;
    assign rsp1_zero   = cap_zero;

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed bench for alu_arbiter. A small ALU model closes the loop on the
// alu_* ports. Expected responses are pushed to a scoreboard queue when an
// operation is accepted and popped when the matching rsp*_valid appears.
// Inputs are driven just after the falling edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]    req0_op, req1_op;
    logic          rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [DW-1:0] rsp0_result, rsp1_result;
    logic          rsp0_zero, rsp1_zero;
    logic [DW-1:0] alu_a, alu_b, alu_result;
    logic [2:0]    alu_op;
    logic          alu_zero;
    logic          busy;
    logic [7:0]    op_count;

    typedef struct {
        int            port;
        logic [DW-1:0] result;
        logic          zero;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    logic [7:0] exp_count;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .busy(busy), .op_count(op_count)
    );

    // Reference ALU: ADD, SUB, AND, OR, XOR; the remaining codes are
    // "undefined" and return an arbitrary but deterministic mix.
    function automatic logic [DW-1:0] ref_alu(input logic [DW-1:0] a, b,
                                              input logic [2:0] op);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b100:  return a ^ b;
            default: return {a[15:0], b[15:0]} ^ 32'hDEAD_BEEF;
        endcase
    endfunction

    always_comb begin
        alu_result = ref_alu(alu_a, alu_b, alu_op);
        alu_zero   = (alu_result == '0);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rsp_valid_of(input int p);
        return (p == 1) ? rsp1_valid : rsp0_valid;
    endfunction

    function automatic logic [DW-1:0] rsp_result_of(input int p);
        return (p == 1) ? rsp1_result : rsp0_result;
    endfunction

    function automatic logic rsp_zero_of(input int p);
        return (p == 1) ? rsp1_zero : rsp0_zero;
    endfunction

    task automatic set_rsp_ready(input int p, input logic v);
        if (p == 1) rsp1_ready = v;
        else        rsp0_ready = v;
    endtask

    // Holds reset for two cycles, checks the reset state, releases on a
    // falling edge. Leaves the bench just after that falling edge.
    task automatic reset_dut();
        rst_n      = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = 3'd0;
        req1_a = '0; req1_b = '0; req1_op = 3'd0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy",       busy,       1'b0);
        check("rst_op_count",   op_count,   8'd0);
        check("rst_rsp0_valid", rsp0_valid, 1'b0);
        check("rst_rsp1_valid", rsp1_valid, 1'b0);
        check("rst_rsp_result", rsp0_result, 32'd0);
        check("rst_rsp_zero",   rsp1_zero,  1'b0);
        check("rst_alu_a",      alu_a,      32'd0);
        check("rst_alu_op",     alu_op,     3'd0);
        check("rst_ready",      {req0_ready, req1_ready}, 2'b00);
        rst_n = 1'b1;
        exp_count = 8'd0;
        sb.delete();
    endtask

    // Presents one request and waits (bounded) until it is accepted; pushes
    // the expected response and returns just after the next falling edge
    // with valid dropped.
    task automatic issue(input int p, input logic [DW-1:0] a, b,
                         input logic [2:0] op);
        int   n = 0;
        exp_t e;
        if (p == 1) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end
        #1;
        while (!((p == 1) ? req1_ready : req0_ready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check("issue_accept_in_time", n < 20, 1'b1);
        e.port   = p;
        e.result = ref_alu(a, b, op);
        e.zero   = (e.result == '0);
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (p == 1) req1_valid = 1'b0;
        else        req0_valid = 1'b0;
        #1;
    endtask

    // Waits (bounded) for a response on port p, compares it with the
    // scoreboard, holds rsp_ready low for 'stall' cycles checking that the
    // response is frozen, then completes the handshake.
    task automatic collect(input int p, input int stall);
        int   n = 0;
        exp_t e;
        while (!rsp_valid_of(p) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check("rsp_valid_in_time", n < 20, 1'b1);
        if (n >= 20 || sb.size() == 0) return;
        e = sb.pop_front();
        check("rsp_port",        p,                  e.port);
        check("rsp_result",      rsp_result_of(p),   e.result);
        check("rsp_zero",        rsp_zero_of(p),     e.zero);
        check("rsp_other_valid", rsp_valid_of(1 - p), 1'b0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk); #1;
            check("stall_valid",  rsp_valid_of(p),  1'b1);
            check("stall_result", rsp_result_of(p), e.result);
            check("stall_zero",   rsp_zero_of(p),   e.zero);
            check("stall_ready",  {req0_ready, req1_ready}, 2'b00);
            check("stall_busy",   busy,             1'b1);
            check("stall_count",  op_count,         exp_count);
        end
        set_rsp_ready(p, 1'b1);
        @(negedge clk);
        set_rsp_ready(p, 1'b0);
        #1;
        exp_count = exp_count + 8'd1;
        check("done_op_count", op_count,        exp_count);
        check("done_busy",     busy,            1'b0);
        check("done_valid",    rsp_valid_of(p), 1'b0);
    endtask

    task automatic do_op(input int p, input logic [DW-1:0] a, b,
                         input logic [2:0] op);
        issue(p, a, b, op);
        collect(p, 0);
    endtask

    initial begin
        int   grants;
        int   last_cyc;
        int   n;
        int   p;
        exp_t e;

        // ---------------- single request, exact latency ----------------
        reset_dut();
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_op = 3'b000;
        #1;
        check("t1_ready0", req0_ready, 1'b1);
        check("t1_ready1", req1_ready, 1'b0);
        e.port = 0; e.result = 32'd12; e.zero = 1'b0;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0; req0_a = 32'hFFFF_FFFF;   // ignored after accept
        #1;
        check("t1_alu_a",      alu_a,      32'd5);
        check("t1_alu_b",      alu_b,      32'd7);
        check("t1_alu_op",     alu_op,     3'b000);
        check("t1_busy",       busy,       1'b1);
        check("t1_exec_valid", rsp0_valid, 1'b0);
        @(negedge clk); #1;
        check("t1_rsp_cycle",  rsp0_valid, 1'b1);
        collect(0, 0);
        check("t1_alu_hold",   alu_a,      32'd5);

        // ---------------- tie, round-robin, back-to-back ----------------
        reset_dut();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd3; req0_op = 3'b001;
        req1_valid = 1'b1; req1_a = 32'd20; req1_b = 32'd6; req1_op = 3'b100;
        #1;
        grants = 0; last_cyc = -1; n = 0;
        while ((grants < 4 || sb.size() != 0) && n < 40) begin
            check("tie_one_ready", req0_ready && req1_ready, 1'b0);
            if (rsp0_valid || rsp1_valid) begin
                p = rsp1_valid ? 1 : 0;
                check("tie_rsp_pending", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("tie_rsp_port",    p,               e.port);
                    check("tie_rsp_result",  rsp_result_of(p), e.result);
                    check("tie_other_valid", rsp_valid_of(1 - p), 1'b0);
                    exp_count = exp_count + 8'd1;
                end
            end
            if (grants < 4 && (req0_ready || req1_ready)) begin
                p = req1_ready ? 1 : 0;
                check("tie_grant_order", p, grants % 2);
                if (last_cyc >= 0) check("tie_spacing", cyc - last_cyc, 3);
                e.port   = p;
                e.result = (p == 1) ? ref_alu(req1_a, req1_b, req1_op)
                                    : ref_alu(req0_a, req0_b, req0_op);
                e.zero   = (e.result == '0);
                sb.push_back(e);
                last_cyc = cyc;
                grants++;
            end else begin
                // Not accepting this cycle: safe to change operands.
                req0_a = $urandom; req0_b = $urandom;
                req1_a = $urandom; req1_b = $urandom;
                if (grants == 4) begin
                    req0_valid = 1'b0; req1_valid = 1'b0;
                end
            end
            @(negedge clk); #1; n++;
        end
        check("tie_finished", n < 40, 1'b1);
        check("tie_grants",   grants, 4);
        check("tie_count",    op_count, exp_count);
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;

        // ---------------- backpressure on port 1 ----------------
        issue(1, 32'd40, 32'd2, 3'b011);
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = 3'b000;
        collect(1, 5);
        // port 0 was waiting the whole time and is now accepted
        check("bp_waiter_ready", req0_ready, 1'b1);
        e.port = 0; e.result = 32'd2; e.zero = 1'b0;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        collect(0, 0);

        // ---------------- zero flag and undefined opcode ----------------
        issue(0, 32'h0000_00FF, 32'h0000_00FF, 3'b001);
        check("zero_sub_valid", rsp0_valid, 1'b0);
        @(negedge clk); #1;
        check("zero_sub_result", rsp0_result, 32'd0);
        check("zero_sub_flag",   rsp0_zero,   1'b1);
        collect(0, 0);
        do_op(1, 32'h1234_5678, 32'h0F0F_0F0F, 3'b110);
        do_op(0, 32'hAAAA_5555, 32'h0000_FFFF, 3'b111);

        // ---------------- op_count wrap ----------------
        n = 0;
        while (exp_count != 8'd255 && n < 300) begin
            do_op(n % 2, n, 32'd1, 3'b000);
            n++;
        end
        check("wrap_at_255", op_count, 8'd255);
        do_op(0, 32'd7, 32'd7, 3'b010);
        check("wrap_to_0", op_count, 8'd0);
        do_op(1, 32'd8, 32'd1, 3'b001);
        check("wrap_to_1", op_count, 8'd1);

        // ---------------- reset during EXEC ----------------
        issue(0, 32'd9, 32'd3, 3'b000);
        check("mid_in_exec", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rsp0_valid", rsp0_valid, 1'b0);
        check("mid_rsp1_valid", rsp1_valid, 1'b0);
        check("mid_busy",       busy,       1'b0);
        check("mid_op_count",   op_count,   8'd0);
        check("mid_alu_a",      alu_a,      32'd0);
        check("mid_alu_b",      alu_b,      32'd0);
        check("mid_alu_op",     alu_op,     3'd0);
        sb.delete();
        exp_count = 8'd0;
        repeat (2) @(negedge clk);
        #1;
        check("mid_still_idle", {rsp0_valid, rsp1_valid, busy}, 3'b000);
        rst_n = 1'b1;
        do_op(1, 32'd100, 32'd1, 3'b001);
        check("mid_after_count", op_count, 8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
